delay_sum_beamformer: RTL
=========================

Name: delay_sum_beamformer

Overview:
- Parametrised delay-and-sum core: accepts one signed PCM frame of NUM_CHANNELS samples at a time.
- Stores each channel in its own circular history buffer and applies a per-channel programmable sample delay.
- Sums the delayed samples sequentially, one channel per clock, and emits one saturated (sum mode) or scaled (average mode) output sample.
- Sits downstream of the I2S deserialisers and upstream of the PCM serialiser; generalises the fixed two-channel shift-buffer path.

Parameters:
- NUM_CHANNELS, 4, channel count; power of two, 2 to 16.
- SAMPLE_WIDTH, 16, bits per signed two's-complement sample.
- DEPTH, 16, history depth per channel; power of two, >=2; maximum delay is DEPTH-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  frame strobe; accepted only when busy=0.
- in_data  input  NUM_CHANNELS*SAMPLE_WIDTH  channel c at bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- cfg_we  input  1  delay register write strobe.
- cfg_ch  input  $clog2(NUM_CHANNELS)  channel index to write.
- cfg_delay  input  $clog2(DEPTH)+1  requested delay in samples.
- avg_mode  input  1  0=saturated sum, 1=arithmetic average; sampled at frame accept.
- busy  output  1  high while a frame is in flight.
- out_valid  output  1  one-cycle pulse with a result.
- out_data  output  SAMPLE_WIDTH  result sample; held until the next out_valid.
- out_sat  output  1  result was clipped; qualified by out_valid.
- overrun  output  1  sticky; frame offered while busy.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; busy=0, out_valid=0, out_data=0, out_sat=0, overrun=0.
  - Write pointer=0, fill count=0, all delay and shadow delay registers=0.
  - Buffer RAM contents are not reset; the fill count masks them.
- Delay config:
  - On cfg_we, delay[cfg_ch] <= min(cfg_delay, DEPTH-1). Writes are allowed in any state.
  - Delays are copied to shadow registers at frame accept, so writes during a frame affect only the next frame.
- FSM states: IDLE -> ACCUM -> OUT -> IDLE.
- IDLE, cycle t, in_valid=1:
  - Write all channels at wr_ptr; captured pointer p=wr_ptr.
  - wr_ptr <= wr_ptr+1 mod DEPTH; fill <= min(fill+1, DEPTH).
  - Latch shadow delays and avg_mode; acc <= 0; ch <= 0; go to ACCUM.
- ACCUM, cycles t+1 .. t+NUM_CHANNELS, one channel per cycle:
  - Term = buf[ch][(p - shadow_delay[ch]) mod DEPTH], sign-extended to ACC_W = SAMPLE_WIDTH + $clog2(NUM_CHANNELS).
  - Term = 0 if shadow_delay[ch] >= fill, where fill includes the current frame.
  - acc <= acc + term. After ch = NUM_CHANNELS-1, go to OUT.
- OUT, cycle t+NUM_CHANNELS+1: out_valid=1, then go to IDLE.
  - Sum mode: clip to [-2^(W-1), 2^(W-1)-1]; out_sat=1 if clipped.
  - Average mode: acc >>> $clog2(NUM_CHANNELS), rounding toward minus infinity; out_sat=0.
- Timing:
  - Latency from accept to out_valid is NUM_CHANNELS+1 cycles.
  - busy = (state != IDLE). Minimum accepted frame spacing is NUM_CHANNELS+2 cycles.
- in_valid while busy: frame dropped, buffers and pointers unchanged, overrun <= 1. overrun clears only on reset.
- Delay 0 returns the sample written in the same frame, so write-before-read is required.
- Wrap-around: pointer arithmetic is modulo DEPTH. After fill saturates, delay DEPTH-1 returns the oldest stored frame.
- Reset mid-frame: the frame is abandoned, no out_valid is produced, and the next frame sees fill=1.

Test Plan:
- Impulse with NUM_CHANNELS=4, W=16, delays {0,1,2,3}: frame 0 = all channels 0x0100, then all-zero frames.
  -> Outputs 0x0100 four times in a row, then 0x0000. out_valid comes 5 cycles after each accept.
- Saturation: all channels 0x7000, delays 0, sum mode.
  -> out_data=0x7FFF, out_sat=1. Repeat with 0x9000 -> 0x8000, out_sat=1.
- Average mode: channels {100, -100, 7, -8}.
  -> acc = -1; out_data = -1 (0xFFFF), since -1 >>> 2 floors to -1; out_sat=0.
- Fill masking and clamp: cfg_delay=20 on channel 2 clamps to 15.
  -> Channel 2 contributes 0 for the first 15 frames. The 16th frame output includes frame 0's channel-2 value. Pointer wraps cleanly over 40 frames.
- Overrun and shadowing: in_valid asserted 2 cycles after an accept; a cfg_we to channel 0 issued during ACCUM.
  -> Second frame dropped, overrun=1 and sticky. The new delay applies only to the next accepted frame.
- Async reset asserted during ACCUM.
  -> busy=0 and out_valid=0 immediately with no result pulse. The next frame behaves as the first after power-up, with delays back to 0.

Source files
------------

// File: rtl/delay_sum_beamformer.sv
// Delay-and-sum beamformer: per-channel circular history with programmable
// delay, sequential accumulation, saturated sum or floor-average output.
module delay_sum_beamformer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] in_data,
  input  logic                                 cfg_we,
  input  logic [$clog2(NUM_CHANNELS)-1:0]      cfg_ch,
  input  logic [$clog2(DEPTH):0]               cfg_delay,
  input  logic                                 avg_mode,
  output logic                                 busy,
  output logic                                 out_valid,
  output logic [SAMPLE_WIDTH-1:0]              out_data,
  output logic                                 out_sat,
  output logic                                 overrun
);

  localparam int W     = SAMPLE_WIDTH;
  localparam int CW    = $clog2(NUM_CHANNELS);
  localparam int PW    = $clog2(DEPTH);
  localparam int DW    = PW + 1;
  localparam int ACC_W = W + CW;

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(CW+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(CW+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]  mem  [NUM_CHANNELS][DEPTH];
  logic [PW-1:0] dly  [NUM_CHANNELS];
  logic [PW-1:0] sdly [NUM_CHANNELS];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] p;
  logic [DW-1:0] fill;
  logic [CW-1:0] ch;
  logic          avg_q;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [W-1:0]            avg_v;
  logic [PW-1:0]           rd_addr;
  logic [W-1:0]            rd;
  logic                    accept;
  logic                    last;
  logic [PW-1:0]           cfg_clamped;

  assign busy   = (state != IDLE);
  assign accept = in_valid && !busy;
  assign last   = (ch == CW'(NUM_CHANNELS-1));

  assign cfg_clamped = (cfg_delay > DW'(DEPTH-1)) ?
                       PW'(DEPTH-1) : cfg_delay[PW-1:0];

  // fill already counts the current frame, so delay >= fill is unwritten RAM
  always_comb begin
    rd_addr = p - sdly[ch];
    rd      = mem[ch][rd_addr];
    term    = '0;
    if ({1'b0, sdly[ch]} < fill)
      term = {{CW{rd[W-1]}}, rd};
    acc_nxt = acc + term;
    avg_v   = W'(acc_nxt >>> CW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (last)   state_nxt = OUT;
      OUT:                 state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        mem[c][wr_ptr] <= in_data[c*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dly         <= '{default: '0};
    else if (cfg_we) dly[cfg_ch] <= cfg_clamped;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      fill      <= '0;
      p         <= '0;
      ch        <= '0;
      acc       <= '0;
      avg_q     <= 1'b0;
      sdly      <= '{default: '0};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid && busy) overrun <= 1'b1;
      if (accept) begin
        p      <= wr_ptr;
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != DW'(DEPTH)) fill <= fill + 1'b1;
        sdly   <= dly;
        avg_q  <= avg_mode;
        acc    <= '0;
        ch     <= '0;
      end
      if (state == ACCUM) begin
        acc <= acc_nxt;
        ch  <= ch + 1'b1;
        if (last) begin
          out_valid <= 1'b1;
          if (avg_q) begin
            out_data <= avg_v;
            out_sat  <= 1'b0;
          end else if (acc_nxt > SMAX) begin
            out_data <= SMAX[W-1:0];
            out_sat  <= 1'b1;
          end else if (acc_nxt < SMIN) begin
            out_data <= SMIN[W-1:0];
            out_sat  <= 1'b1;
          end else begin
            out_data <= acc_nxt[W-1:0];
            out_sat  <= 1'b0;
          end
        end
      end
    end
  end

endmodule
